uart_tx: RTL and testbench

- Transmit serializer on the read side of the TX `uart_fifo`.
- Pops bytes from the FIFO using a first-word-fall-through read interface.
- Frames each byte as start, data LSB-first, optional parity and stop bits, and drives the UART TX line.
- Bit timing comes from a programmable clock divider; back-to-back frames are sent with no idle gap.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 46 ++++
 rtl/uart_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Brief    : Shared UART types and line-level constants.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Transmitter frame states; TX_PARITY is only reachable when the
  // parity feature is compiled in.
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_baud_gen                                             |
// | Brief    : Loadable bit-period down-counter. tick_o marks the last   |
// |            clock of a bit period; tick_next_o is the same flag one   |
// |            cycle early so callers can build registered end strobes.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             tick_next_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Reload on a bit boundary, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = (cnt_q == '0);
  assign tick_next_o = (cnt_d == '0);

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx                                                   |
// | Brief    : UART transmit serializer fed by a first-word-fall-through |
// |            FIFO. Frames: start, DATA_W bits LSB first, optional      |
// |            parity, one or two stop bits. Frames run back-to-back     |
// |            while data is available.                                  |
// | Options  : define UART_TX_PARITY_EN to compile in the parity bit.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic              stop2_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              fifo_pop_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  // Bit counter is 3 bits wide because DATA_W never exceeds 8.
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  uart_tx_state_t    state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic              stop2_q,   stop2_d;
  logic              tx_q,      tx_d;
  logic              busy_q,    busy_d;
  logic              pop_q,     pop_d;
  logic              done_q,    done_d;

`ifdef UART_TX_PARITY_EN
  logic              par_en_q,  par_en_d;
  logic              par_bit_q, par_bit_d;
`else
  // Parity controls have no effect in this build.
  logic              unused_parity;
  assign unused_parity = parity_en_i ^ parity_odd_i;
`endif

  logic              start_ok;
  logic              start_frame;
  logic              load_w;
  logic [DIV_W-1:0]  load_val_w;
  logic              tick_w;
  logic              tick_next_w;

  assign start_ok = en_i & ~fifo_empty_i;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .load_i      (load_w),
    .div_i       (load_val_w),
    .tick_o      (tick_w),
    .tick_next_o (tick_next_w)
  );

  // Next-state, line level and frame bookkeeping; a new frame may start
  // from IDLE or directly from the last stop cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    div_d       = div_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    pop_d       = 1'b0;
    load_w      = 1'b0;
    load_val_w  = div_q;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif

    case (state_q)
      TX_IDLE: begin
        tx_d   = UART_IDLE_LEVEL;
        busy_d = 1'b0;
        if (start_ok) begin
          start_frame = 1'b1;
        end
      end

      TX_START: begin
        if (tick_w) begin
          state_d = TX_DATA;
          tx_d    = shift_q[0];
          load_w  = 1'b1;
        end
      end

      TX_DATA: begin
        if (tick_w) begin
          load_w = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = TX_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = TX_STOP;
              tx_d    = UART_IDLE_LEVEL;
            end
`else
            state_d = TX_STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (tick_w) begin
          state_d = TX_STOP;
          tx_d    = UART_IDLE_LEVEL;
          load_w  = 1'b1;
        end
      end
`endif

      TX_STOP: begin
        if (tick_w) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            load_w     = 1'b1;
          end else if (start_ok) begin
            start_frame = 1'b1;
          end else begin
            state_d = TX_IDLE;
            tx_d    = UART_IDLE_LEVEL;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = TX_IDLE;
        tx_d    = UART_IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase

    // Frame launch: capture the FIFO head and all per-frame settings.
    if (start_frame) begin
      state_d    = TX_START;
      shift_d    = fifo_rdata_i;
      bit_cnt_d  = 3'd0;
      stop_cnt_d = 1'b0;
      div_d      = baud_div_i;
      stop2_d    = stop2_i;
      tx_d       = UART_START_LEVEL;
      busy_d     = 1'b1;
      pop_d      = 1'b1;
      load_w     = 1'b1;
      load_val_w = baud_div_i;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en_i;
      par_bit_d  = (^fifo_rdata_i) ^ parity_odd_i;
`endif
    end
  end

  // done_o is registered, so it is raised on the edge that enters the
  // final cycle of the last stop bit.
  always_comb begin
    done_d = (state_d == TX_STOP) && (!stop2_q || stop_cnt_d) && tick_next_w;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      pop_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pop_q      <= pop_d;
      done_q     <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Per-frame parity settings captured at frame start.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  assign fifo_pop_o = pop_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                |
// | Brief    : Self-checking bench for uart_tx with a queue-based FIFO   |
// |            and a bit-list frame model. Honours UART_TX_PARITY_EN.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              en_i = 1'b0;
  logic [DIV_W-1:0]  baud_div_i = '0;
  logic              stop2_i = 1'b0;
  logic              parity_en_i = 1'b0;
  logic              parity_odd_i = 1'b0;
  logic              fifo_empty_i = 1'b1;
  logic [DATA_W-1:0] fifo_rdata_i = '0;
  logic              fifo_pop_o;
  logic              tx_o;
  logic              busy_o;
  logic              done_o;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] stim_q[$];
  bit         exp_bits[$];

  uart_tx #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .baud_div_i   (baud_div_i),
    .stop2_i      (stop2_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_pop_o   (fifo_pop_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: consume the head on a pop strobe; never pop when empty.
  always @(posedge clk_i) begin
    if (fifo_pop_o) begin
      pop_cnt++;
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL pop_when_empty: pop=1 with empty FIFO, want no pop");
      end else begin
        void'(fifo_q.pop_front());
      end
    end
  end

  // First-word-fall-through view of the FIFO, refreshed away from the edge.
  always @(negedge clk_i) begin
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line levels, one entry per bit period.
  function automatic void build_bits(input logic [7:0] d, input bit pe, input bit po, input bit s2);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int b = 0; b < DATA_W; b++) exp_bits.push_back(d[b]);
    if (PAR_BUILT && pe) exp_bits.push_back((^d) ^ po);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
  endfunction

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (tx_o !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (fifo_pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop_o); end
    checks++; if (done_o !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
  endtask

  // Sends stim_q back-to-back and checks every clock of every frame.
  task automatic run_frames(input string name, input int div, input bit s2,
                            input bit pe, input bit po, input bit chg_div);
    int  base, n, per, len;
    bit  found;
    n    = stim_q.size();
    base = pop_cnt;
    per  = div + 1;
    baud_div_i   = DIV_W'(div);
    stop2_i      = s2;
    parity_en_i  = pe;
    parity_odd_i = po;
    en_i         = 1'b1;
    foreach (stim_q[k]) fifo_q.push_back(stim_q[k]);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_i); #1;
      if (fifo_pop_o) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_start: pop=0 after 20 cycles, want 1", name);
      en_i = 1'b0;
      fifo_q.delete();
      repeat (200) @(posedge clk_i);
      return;
    end
    if (chg_div) baud_div_i = DIV_W'(div + 5);
    for (int k = 0; k < n; k++) begin
      build_bits(stim_q[k], pe, po, s2);
      len = exp_bits.size() * per;
      for (int i = 0; i < len; i++) begin
        checks++;
        if (tx_o !== exp_bits[i / per]) begin
          errors++;
          $display("FAIL %s_tx: frame %0d cycle %0d got %b want %b", name, k, i, tx_o, exp_bits[i / per]);
        end
        checks++;
        if (fifo_pop_o !== (i == 0)) begin
          errors++;
          $display("FAIL %s_pop: frame %0d cycle %0d got %b want %b", name, k, i, fifo_pop_o, (i == 0));
        end
        checks++;
        if (done_o !== (i == len - 1)) begin
          errors++;
          $display("FAIL %s_done: frame %0d cycle %0d got %b want %b", name, k, i, done_o, (i == len - 1));
        end
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_busy: frame %0d cycle %0d got %b want 1", name, k, i, busy_o);
        end
        @(posedge clk_i); #1;
      end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0", name, busy_o); end
    checks++; if (tx_o !== 1'b1)   begin errors++; $display("FAIL %s_tx_end: got %b want 1", name, tx_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL %s_done_end: got %b want 0", name, done_o); end
    checks++;
    if (pop_cnt - base != n) begin
      errors++;
      $display("FAIL %s_pop_count: got %0d want %0d", name, pop_cnt - base, n);
    end
    baud_div_i = DIV_W'(div);
  endtask

  task automatic test_single();
    stim_q.delete(); stim_q.push_back(8'hA5);
    run_frames("single", 3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    stim_q.delete(); stim_q.push_back(8'h00); stim_q.push_back(8'hFF);
    run_frames("b2b", 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop2();
    stim_q.delete(); stim_q.push_back(8'(($urandom)));
    run_frames("stop2", 1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    stim_q.delete(); stim_q.push_back(8'h07);
    run_frames("par_even", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frames("par_odd",  1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frames("par_off",  1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      stim_q.delete();
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) stim_q.push_back(8'($urandom));
      run_frames("random", int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_empty();
    en_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (fifo_pop_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle: cycle %0d pop=%b tx=%b busy=%b want 0/1/0", i, fifo_pop_o, tx_o, busy_o);
      end
    end
    en_i = 1'b0;
    fifo_q.push_back(8'h11);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (fifo_pop_o !== 1'b0 || tx_o !== 1'b1) begin
        errors++;
        $display("FAIL disabled_idle: cycle %0d pop=%b tx=%b want 0/1", i, fifo_pop_o, tx_o);
      end
    end
    fifo_q.delete();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_en_drop();
    int  base, len;
    bit  found;
    base = pop_cnt;
    baud_div_i = DIV_W'(1); stop2_i = 1'b0; parity_en_i = 1'b0;
    en_i = 1'b1;
    fifo_q.push_back(8'h3C); fifo_q.push_back(8'hC3);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_i); #1;
      if (fifo_pop_o) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL endrop_start: pop=0 after 20 cycles, want 1"); end
    build_bits(8'h3C, 1'b0, 1'b0, 1'b0);
    len = exp_bits.size() * 2;
    for (int i = 0; i < len; i++) begin
      if (i == 6) en_i = 1'b0;
      checks++;
      if (tx_o !== exp_bits[i / 2] || done_o !== (i == len - 1)) begin
        errors++;
        $display("FAIL endrop_frame: cycle %0d tx=%b done=%b want %b/%b", i, tx_o, done_o, exp_bits[i / 2], (i == len - 1));
      end
      @(posedge clk_i); #1;
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (fifo_pop_o !== 1'b0 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
        errors++;
        $display("FAIL endrop_idle: cycle %0d pop=%b busy=%b tx=%b want 0/0/1", i, fifo_pop_o, busy_o, tx_o);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (pop_cnt - base != 1 || fifo_q.size() != 1) begin
      errors++;
      $display("FAIL endrop_pops: pops=%0d left=%0d want 1/1", pop_cnt - base, fifo_q.size());
    end
    fifo_q.delete();
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_reset_mid();
    int  base, len;
    bit  found;
    baud_div_i = DIV_W'(1); stop2_i = 1'b0; parity_en_i = 1'b0;
    en_i = 1'b1;
    fifo_q.push_back(8'h5A);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_i); #1;
      if (fifo_pop_o) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_start: pop=0 after 20 cycles, want 1"); end
    repeat (8) begin @(posedge clk_i); #1; end
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_bit3: got %b want 1", tx_o); end
    rstn_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: tx=%b busy=%b pop=%b done=%b want 1/0/0/0", tx_o, busy_o, fifo_pop_o, done_o);
    end
    fifo_q.push_back(8'h96);
    repeat (2) begin
      @(posedge clk_i); #1;
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold: tx=%b busy=%b pop=%b want 1/0/0", tx_o, busy_o, fifo_pop_o);
      end
    end
    base = pop_cnt;
    rstn_i = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_i); #1;
      if (fifo_pop_o) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_restart: pop=0 after 20 cycles, want 1"); end
    build_bits(8'h96, 1'b0, 1'b0, 1'b0);
    len = exp_bits.size() * 2;
    for (int i = 0; i < len; i++) begin
      checks++;
      if (tx_o !== exp_bits[i / 2]) begin
        errors++;
        $display("FAIL rstmid_frame: cycle %0d got %b want %b", i, tx_o, exp_bits[i / 2]);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (busy_o !== 1'b0 || pop_cnt - base != 1) begin
      errors++;
      $display("FAIL rstmid_end: busy=%b pops=%0d want 0/1", busy_o, pop_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stop2();
    test_parity();
    test_empty();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx
`default_nettype wire
